mem_arbiter: RTL

- Shares the single 256x8 unified memory between three requesters:
  - loader port (program/debug image load, highest priority);
  - processor data port (LOAD/STORE);
  - processor instruction-fetch port.
- Sequences every access through a 3-state FSM onto one synchronous single-port RAM interface with 1-cycle read latency.
- Replaces the direct combinational memory[] reads in the processor, so fetch and data accesses no longer collide.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-port arbiter onto one synchronous single-port RAM
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_DM, OWN_IF} owner_t;

    state_t            state, state_next;
    owner_t            owner, grant;
    logic              rr_last_if;
    logic              op_we;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] ld_rdata_q, dm_rdata_q, if_rdata_q;

    // Loader always wins at IDLE; DM/IF ties go to whichever did not go last.
    always_comb begin
        grant     = OWN_NONE;
        sel_we    = 1'b0;
        sel_addr  = mem_addr;
        sel_wdata = mem_wdata;
        if (ld_req) begin
            grant = OWN_LD;
        end else if (dm_req && if_req) begin
            grant = rr_last_if ? OWN_DM : OWN_IF;
        end else if (dm_req) begin
            grant = OWN_DM;
        end else if (if_req) begin
            grant = OWN_IF;
        end
        case (grant)
            OWN_LD: begin
                sel_we    = ld_we;
                sel_addr  = ld_addr;
                sel_wdata = ld_wdata;
            end
            OWN_DM: begin
                sel_we    = dm_we;
                sel_addr  = dm_addr;
                sel_wdata = dm_wdata;
            end
            OWN_IF: begin
                sel_addr  = if_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant != OWN_NONE) state_next = S_ISSUE;
            S_ISSUE: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= OWN_NONE;
            rr_last_if <= 1'b1;
            op_we      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ld_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant != OWN_NONE) begin
                        owner     <= grant;
                        op_we     <= sel_we;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                    end
                end
                S_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (owner == OWN_DM) rr_last_if <= 1'b0;
                    if (owner == OWN_IF) rr_last_if <= 1'b1;
                end
                S_RESP: begin
                    // RAM data is live during RESP; keep a copy so rdata holds afterwards.
                    if (!op_we) begin
                        case (owner)
                            OWN_LD:  ld_rdata_q <= mem_rdata;
                            OWN_DM:  dm_rdata_q <= mem_rdata;
                            OWN_IF:  if_rdata_q <= mem_rdata;
                            default: ;
                        endcase
                    end
                    owner <= OWN_NONE;
                end
                default: ;
            endcase
        end
    end

    assign ld_ack   = (state == S_RESP) && (owner == OWN_LD);
    assign dm_ack   = (state == S_RESP) && (owner == OWN_DM);
    assign if_ack   = (state == S_RESP) && (owner == OWN_IF);
    assign ld_rdata = (ld_ack && !op_we) ? mem_rdata : ld_rdata_q;
    assign dm_rdata = (dm_ack && !op_we) ? mem_rdata : dm_rdata_q;
    assign if_rdata = (if_ack && !op_we) ? mem_rdata : if_rdata_q;
    assign busy     = (state != S_IDLE);

endmodule
